// File: rtl/cpu_ifetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Fetch buffer entries carry the instruction word together with its address.
package cpu_ifetch_pkg;

  localparam logic [31:0] RESET_VECTOR       = 32'hFFFF_0000;
  localparam logic [3:0]  PERF_FETCH_STARVED = 4'd5;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/cpu_ifetch_if.sv
// Fetch-side bus bundle: instruction memory port, decode handshake and redirect.
// master is the fetch stage; slave is the memory/decoder/ALU environment.
interface cpu_ifetch_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        p2_valid;
  logic [31:0] p2_instr;
  logic [31:0] p2_pc;
  logic        p2_ready;
  logic        p4_jump;
  logic [31:0] p4_jump_addr;
  logic        fetch_starved;

  modport master (
    output imem_req, imem_addr, p2_valid, p2_instr, p2_pc, fetch_starved,
    input  imem_ack, imem_rvalid, imem_rdata, p2_ready, p4_jump, p4_jump_addr
  );

  modport slave (
    input  imem_req, imem_addr, p2_valid, p2_instr, p2_pc, fetch_starved,
    output imem_ack, imem_rvalid, imem_rdata, p2_ready, p4_jump, p4_jump_addr
  );

endinterface

// File: rtl/cpu_ifetch_fifo.sv
// Synchronous instruction buffer of {instr, pc} entries; flush overrides push and pop.
// A pushed entry becomes visible at the head one cycle later (no fall-through).
module cpu_ifetch_fifo
  import cpu_ifetch_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CW    = AW + 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  fetch_entry_t  wdata,
  output fetch_entry_t  rdata,
  output logic [CW-1:0] count
);

  fetch_entry_t   mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic           do_push;
  logic           do_pop;

  assign do_pop  = pop && (count != '0);
  // Writing into a full buffer is only legal when the head leaves in the same cycle.
  assign do_push = push && ((count != CW'(DEPTH)) || do_pop);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clock) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];

endmodule

// File: rtl/cpu_ifetch.sv
// Instruction fetch stage: credit-gated in-order word fetches, buffered for decode.
// A redirect flushes the buffer and drops the responses of requests already in flight.
module cpu_ifetch
  import cpu_ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_VECTOR,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input logic          clock,
  input logic          reset,
  cpu_ifetch_if.master bus
);

  localparam int unsigned CW      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(FIFO_DEPTH);

  logic [31:0]   fetch_pc;
  logic [31:0]   resp_pc;
  logic [31:0]   target;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] discard;
  logic [CW-1:0] fifo_count;
  logic [CW:0]   credit_used;
  logic          run;
  logic          accept;
  logic          dropping;
  logic          push;
  logic          pop;
  fetch_entry_t  wr_entry;
  fetch_entry_t  head;
  logic          unused_jump_lsbs;

  assign unused_jump_lsbs = ^bus.p4_jump_addr[1:0];
  assign target           = word_align(bus.p4_jump_addr);

  // Every request in flight owns a buffer slot, so a response never finds the buffer full.
  assign credit_used   = {1'b0, outstanding} + {1'b0, fifo_count};
  assign bus.imem_req  = run && !bus.p4_jump && (credit_used < DEPTH_C);
  assign bus.imem_addr = fetch_pc;
  assign accept        = bus.imem_req && bus.imem_ack;

  assign dropping = (discard != '0);
  assign push     = bus.imem_rvalid && !dropping;
  assign pop      = bus.p2_valid && bus.p2_ready;
  assign wr_entry = '{instr: bus.imem_rdata, pc: resp_pc};

  cpu_ifetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (bus.p4_jump),
    .wdata (wr_entry),
    .rdata (head),
    .count (fifo_count)
  );

  assign bus.p2_valid = (fifo_count != '0);
  assign bus.p2_instr = head.instr;
  assign bus.p2_pc    = head.pc;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      run               <= 1'b0;
      fetch_pc          <= RESET_PC;
      resp_pc           <= RESET_PC;
      outstanding       <= '0;
      discard           <= '0;
      bus.fetch_starved <= 1'b0;
    end else begin
      run               <= 1'b1;
      bus.fetch_starved <= bus.p2_ready && !bus.p2_valid && !bus.p4_jump;

      case ({accept, bus.imem_rvalid})
        2'b10:   outstanding <= outstanding + CW'(1);
        2'b01:   outstanding <= outstanding - CW'(1);
        default: outstanding <= outstanding;
      endcase

      if (bus.p4_jump) begin
        // Everything still in flight after this cycle belongs to the old path.
        fetch_pc <= target;
        resp_pc  <= target;
        discard  <= outstanding - CW'(bus.imem_rvalid);
      end else begin
        if (accept) fetch_pc <= fetch_pc + 32'd4;
        if (bus.imem_rvalid) begin
          if (dropping) discard <= discard - CW'(1);
          else          resp_pc <= resp_pc + 32'd4;
        end
      end
    end
  end

endmodule

// File: tb/tb_cpu_ifetch.sv
// Directed bench for cpu_ifetch: queue-based reference model checked every cycle,
// plus literal expectations on accepted addresses and decoded pc sequences.
module tb_cpu_ifetch;
  import cpu_ifetch_pkg::*;

  localparam int          DEPTH  = 4;
  localparam logic [31:0] RST_PC = 32'hFFFF_0000;
  localparam logic [31:0] KEY    = 32'h5A5A_5A5A;

  logic clock = 1'b0;
  logic reset = 1'b0;

  cpu_ifetch_if bus();

  cpu_ifetch #(.RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  logic [31:0] mem_q[$];
  logic [31:0] acc_log[$];
  logic [31:0] pop_log[$];
  int first_acc_cyc = -1;
  int first_val_cyc = -1;

  logic [31:0] m_fetch_pc, m_resp_pc;
  int          m_out, m_disc;
  logic        m_run, m_starved;
  logic [31:0] m_fifo_pc[$];
  logic [31:0] m_fifo_instr[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_q(input string name, input logic [31:0] q[$], input int idx,
                         input logic [31:0] exp);
    if (idx >= q.size()) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: entry %0d missing (size %0d) expected %h", name, idx, q.size(), exp);
    end else begin
      check(name, q[idx], exp);
    end
  endtask

  task automatic model_reset();
    m_fetch_pc = RST_PC;
    m_resp_pc  = RST_PC;
    m_out      = 0;
    m_disc     = 0;
    m_run      = 1'b0;
    m_starved  = 1'b0;
    m_fifo_pc.delete();
    m_fifo_instr.delete();
  endtask

  task automatic clear_logs();
    acc_log.delete();
    pop_log.delete();
  endtask

  // One clock cycle: drive inputs, compare every output with the model, advance the model.
  task automatic step(input logic rst_v, input logic rdy, input logic ack, input logic rsp,
                      input logic jmp, input logic [31:0] jaddr);
    logic        exp_req;
    logic        rv;
    logic [31:0] rd;
    logic        fifo_has;
    @(negedge clock);
    cyc++;
    reset            = rst_v;
    bus.p2_ready     = rdy;
    bus.imem_ack     = ack;
    bus.p4_jump      = jmp;
    bus.p4_jump_addr = jaddr;
    rv = 1'b0;
    rd = '0;
    if (!rst_v) begin
      mem_q.delete();
      model_reset();
    end else if (rsp && mem_q.size() != 0) begin
      rv = 1'b1;
      rd = mem_q.pop_front() ^ KEY;
    end
    bus.imem_rvalid = rv;
    bus.imem_rdata  = rd;
    #1;
    fifo_has = (m_fifo_pc.size() != 0);
    exp_req  = m_run && !jmp && ((m_out + int'(m_fifo_pc.size())) < DEPTH);
    check("imem_req", 32'(bus.imem_req), 32'(exp_req));
    check("imem_addr", bus.imem_addr, m_fetch_pc);
    check("p2_valid", 32'(bus.p2_valid), 32'(fifo_has));
    if (fifo_has) begin
      check("p2_pc", bus.p2_pc, m_fifo_pc[0]);
      check("p2_instr", bus.p2_instr, m_fifo_instr[0]);
    end
    check("fetch_starved", 32'(bus.fetch_starved), 32'(m_starved));
    if (!rst_v) return;

    if (bus.imem_req && ack) begin
      mem_q.push_back(bus.imem_addr);
      acc_log.push_back(bus.imem_addr);
      if (first_acc_cyc < 0) first_acc_cyc = cyc;
    end
    if (bus.p2_valid && first_val_cyc < 0) first_val_cyc = cyc;
    if (bus.p2_valid && rdy && !jmp) pop_log.push_back(bus.p2_pc);

    m_starved = rdy && !fifo_has && !jmp;
    if (jmp) begin
      m_fifo_pc.delete();
      m_fifo_instr.delete();
      if (rv) m_out--;
      m_disc     = m_out;
      m_fetch_pc = jaddr & 32'hFFFF_FFFC;
      m_resp_pc  = jaddr & 32'hFFFF_FFFC;
    end else begin
      if (fifo_has && rdy) begin
        void'(m_fifo_pc.pop_front());
        void'(m_fifo_instr.pop_front());
      end
      if (rv) begin
        m_out--;
        if (m_disc > 0) m_disc--;
        else begin
          m_fifo_pc.push_back(m_resp_pc);
          m_fifo_instr.push_back(rd);
          m_resp_pc = m_resp_pc + 32'd4;
        end
      end
      if (exp_req && ack) begin
        m_out++;
        m_fetch_pc = m_fetch_pc + 32'd4;
      end
    end
    m_run = 1'b1;
  endtask

  initial begin
    bus.p2_ready     = 1'b0;
    bus.imem_ack     = 1'b0;
    bus.imem_rvalid  = 1'b0;
    bus.imem_rdata   = '0;
    bus.p4_jump      = 1'b0;
    bus.p4_jump_addr = '0;
    model_reset();

    // Reset state
    repeat (3) step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    check("rst_addr", bus.imem_addr, 32'hFFFF_0000);
    check("rst_req", 32'(bus.imem_req), 32'd0);
    check("rst_p2_valid", 32'(bus.p2_valid), 32'd0);

    // Streaming from the reset vector with a one-cycle memory
    clear_logs();
    repeat (12) step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    check_q("stream_acc0", acc_log, 0, 32'hFFFF_0000);
    check_q("stream_acc1", acc_log, 1, 32'hFFFF_0004);
    check_q("stream_acc2", acc_log, 2, 32'hFFFF_0008);
    check_q("stream_pop0", pop_log, 0, 32'hFFFF_0000);
    check_q("stream_pop1", pop_log, 1, 32'hFFFF_0004);
    check("stream_valid_latency", 32'(first_val_cyc - first_acc_cyc), 32'd2);

    // Three requests in flight, then redirect to an unaligned target
    repeat (5) step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    clear_logs();
    repeat (3) step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    check("jump_pre_outstanding", 32'(acc_log.size()), 32'd3);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_1002);
    clear_logs();
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    check("jump_next_addr", bus.imem_addr, 32'h0000_1000);
    check("jump_next_req", 32'(bus.imem_req), 32'd1);
    repeat (12) step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    check_q("jump_pop0", pop_log, 0, 32'h0000_1000);
    check_q("jump_pop1", pop_log, 1, 32'h0000_1004);

    // Redirect coinciding with a response while the buffer is half full
    repeat (5) step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_2000);
    check("half_valid_in_jump", 32'(bus.p2_valid), 32'd1);
    clear_logs();
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    check("half_flushed", 32'(bus.p2_valid), 32'd0);
    repeat (10) step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    check_q("half_acc0", acc_log, 0, 32'h0000_2000);
    check_q("half_pop0", pop_log, 0, 32'h0000_2000);

    // Address wrap at the top of the address space
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFF8);
    clear_logs();
    repeat (10) step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    check_q("wrap_acc0", acc_log, 0, 32'hFFFF_FFF8);
    check_q("wrap_acc1", acc_log, 1, 32'hFFFF_FFFC);
    check_q("wrap_acc2", acc_log, 2, 32'h0000_0000);
    check_q("wrap_acc3", acc_log, 3, 32'h0000_0004);
    check_q("wrap_pop1", pop_log, 1, 32'hFFFF_FFFC);
    check_q("wrap_pop2", pop_log, 2, 32'h0000_0000);

    // Asynchronous reset with two requests in flight
    repeat (5) step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    repeat (2) step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    check("mid_rst_req", 32'(bus.imem_req), 32'd0);
    check("mid_rst_addr", bus.imem_addr, 32'hFFFF_0000);
    check("mid_rst_valid", 32'(bus.p2_valid), 32'd0);
    check("mid_rst_starved", 32'(bus.fetch_starved), 32'd0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    clear_logs();
    repeat (8) step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    check_q("restart_acc0", acc_log, 0, 32'hFFFF_0000);
    check_q("restart_pop0", pop_log, 0, 32'hFFFF_0000);

    // Decoder stalled from reset: exactly DEPTH fetches, then one per freed slot
    repeat (2) step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    clear_logs();
    repeat (12) step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    check("bp_accepts", 32'(acc_log.size()), 32'd4);
    check("bp_req_low", 32'(bus.imem_req), 32'd0);
    clear_logs();
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    repeat (4) step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    check("bp_refill_accepts", 32'(acc_log.size()), 32'd1);
    check_q("bp_refill_addr", acc_log, 0, 32'hFFFF_0010);
    check_q("bp_pop0", pop_log, 0, 32'hFFFF_0000);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
